// File: rtl/ienc_pkg.sv
// rtl/ienc_pkg.sv - shared FSM state, branch opcodes and instruction field positions
package ienc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } ienc_state_t;

    // Branch-class opcodes
    localparam logic [3:0] OP_BR_0 = 4'b0000;
    localparam logic [3:0] OP_BR_1 = 4'b1011;
    localparam logic [3:0] OP_BR_2 = 4'b1100;
    localparam logic [3:0] OP_BR_3 = 4'b1101;
    localparam logic [3:0] OP_BR_4 = 4'b1110;

    // Field bit positions, shared with the instruction decoder
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int DEST_MSB  = 11;
    localparam int DEST_LSB  = 9;
    localparam int Q0_MSB    = 8;
    localparam int Q0_LSB    = 6;
    localparam int Q1_MSB    = 5;
    localparam int Q1_LSB    = 3;
    localparam int IMM_MSB   = 5;
    localparam int IMM_LSB   = 2;
    localparam int IMMB_MSB  = 11;
    localparam int IMMB_LSB  = 1;
    localparam int FLAG_BIT  = 1;
    localparam int ISEL_BIT  = 0;

    function automatic logic is_branch(input logic [3:0] op);
        logic br;
        case (op)
            OP_BR_0, OP_BR_1, OP_BR_2, OP_BR_3, OP_BR_4: br = 1'b1;
            default:                                     br = 1'b0;
        endcase
        return br;
    endfunction

endpackage

// File: rtl/ienc_pack.sv
// rtl/ienc_pack.sv - combinational packing of decoded fields into a 16-bit instruction word
module ienc_pack
    import ienc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [2:0]  dest,
    input  logic [2:0]  q0,
    input  logic [2:0]  q1,
    input  logic [3:0]  imm,
    input  logic [10:0] imm_b,
    input  logic        flag_en,
    input  logic        immed_sel,
    output logic [15:0] word
);

    // Branch words carry only the opcode and the long immediate; bit 0 stays zero
    always_comb begin
        word = '0;
        word[OP_MSB:OP_LSB] = op;
        if (is_branch(op)) begin
            word[IMMB_MSB:IMMB_LSB] = imm_b;
        end else begin
            word[DEST_MSB:DEST_LSB] = dest;
            word[Q0_MSB:Q0_LSB]     = q0;
            word[FLAG_BIT]          = flag_en;
            word[ISEL_BIT]          = immed_sel;
            if (immed_sel) begin
                word[IMM_MSB:IMM_LSB] = imm;
            end else begin
                word[Q1_MSB:Q1_LSB] = q1;
            end
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - field encoder and sequential program loader (optional IENC_CHECKSUM_EN)
module instruction_encoder
    import ienc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_dest,
    input  logic [2:0]        in_q0,
    input  logic [2:0]        in_q1,
    input  logic [3:0]        in_imm,
    input  logic [10:0]       in_imm_b,
    input  logic              in_flag_en,
    input  logic              in_immed_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    ienc_state_t       state_q;
    ienc_state_t       state_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic [CNT_W-1:0]  remaining;
    logic [15:0]       packed_word;
    logic              start_load;
    logic              accept;

    ienc_pack u_pack (
        .op        (in_op),
        .dest      (in_dest),
        .q0        (in_q0),
        .q1        (in_q1),
        .imm       (in_imm),
        .imm_b     (in_imm_b),
        .flag_en   (in_flag_en),
        .immed_sel (in_immed_sel),
        .word      (packed_word)
    );

    // in_ready comes from registered state only, so it never depends on in_valid
    assign in_ready   = (state_q == ST_LOAD) && (remaining != '0);
    assign accept     = in_valid && in_ready;
    assign start_load = start && (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FLUSH lets the last registered write retire before done
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? ST_FLUSH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (remaining == CNT_W'(1))) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters and the registered write stage; done is raised on leaving FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt  <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            mem_we <= accept;
            done   <= (state_q == ST_FLUSH);
            if (start_load) begin
                addr_cnt  <= base_addr;
                remaining <= count;
            end else if (accept) begin
                mem_addr  <= addr_cnt;
                mem_wdata <= packed_word;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

`ifdef IENC_CHECKSUM_EN
    logic [15:0] checksum_q;

    // XOR of every word as it appears on the memory bus; holds after done
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_load) begin
            checksum_q <= '0;
        end else if (mem_we) begin
            checksum_q <= checksum_q ^ mem_wdata;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_dest;
    logic [2:0]  in_q0;
    logic [2:0]  in_q1;
    logic [3:0]  in_imm;
    logic [10:0] in_imm_b;
    logic        in_flag_en;
    logic        in_immed_sel;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int checks;
    int failures;
    int done_seen;
    logic [7:0]  log_addr[$];
    logic [15:0] log_data[$];

    instruction_encoder #(.ADDR_W(8), .CNT_W(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_dest      (in_dest),
        .in_q0        (in_q0),
        .in_q1        (in_q1),
        .in_imm       (in_imm),
        .in_imm_b     (in_imm_b),
        .in_flag_en   (in_flag_en),
        .in_immed_sel (in_immed_sel),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        if (done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] op, input logic [2:0] dest, input logic [2:0] q0,
                              input logic [2:0] q1, input logic [3:0] imm, input logic [10:0] imm_b,
                              input logic fe, input logic isel);
        in_op = op; in_dest = dest; in_q0 = q0; in_q1 = q1;
        in_imm = imm; in_imm_b = imm_b; in_flag_en = fe; in_immed_sel = isel;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 8'h00)  begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (checksum !== 16'h0)  begin failures++; $display("FAIL reset_checksum got=%h exp=0000", checksum); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_log();
        base_addr = 8'h10; count = 9'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_start got=%b exp=1", in_ready); end
        set_fields(4'b0001, 3'd2, 3'd3, 3'd4, 4'h0, 11'h0, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'h14E2)
            begin failures++; $display("FAIL basic_w0 got we=%b addr=%h data=%h exp we=1 addr=10 data=14e2", mem_we, mem_addr, mem_wdata); end
        set_fields(4'b1011, 3'd7, 3'd7, 3'd7, 4'hF, 11'h5A5, 1'b1, 1'b1);
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 16'hBB4A)
            begin failures++; $display("FAIL basic_w1_branch got we=%b addr=%h data=%h exp we=1 addr=11 data=bb4a", mem_we, mem_addr, mem_wdata); end
        set_fields(4'b0010, 3'd1, 3'd0, 3'd5, 4'hF, 11'h0, 1'b0, 1'b1);
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h12 || mem_wdata !== 16'h223D)
            begin failures++; $display("FAIL basic_w2_imm got we=%b addr=%h data=%h exp we=1 addr=12 data=223d", mem_we, mem_addr, mem_wdata); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
            begin failures++; $display("FAIL basic_flush got ready=%b busy=%b done=%b exp 0 1 0", in_ready, busy, done); end
        tick();
        in_valid = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0)
            begin failures++; $display("FAIL basic_done got done=%b busy=%b we=%b exp 1 0 0", done, busy, mem_we); end
`ifdef IENC_CHECKSUM_EN
        checks++; if (checksum !== 16'h8D95) begin failures++; $display("FAIL basic_checksum got=%h exp=8d95", checksum); end
`else
        checks++; if (checksum !== 16'h0) begin failures++; $display("FAIL basic_checksum got=%h exp=0000", checksum); end
`endif
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (log_addr.size() !== 3) begin failures++; $display("FAIL basic_write_count got=%0d exp=3", log_addr.size()); end
    endtask

    task automatic test_wrap();
        clear_log();
        base_addr = 8'hFF; count = 9'd2; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        set_fields(4'b1110, 3'd0, 3'd0, 3'd0, 4'h0, 11'h001, 1'b0, 1'b0);
        tick();
        set_fields(4'b0000, 3'd5, 3'd5, 3'd5, 4'h5, 11'h7FF, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL wrap_write_count got=%0d exp=2", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 8'hFF || log_data[0] !== 16'hE002)
                begin failures++; $display("FAIL wrap_first got addr=%h data=%h exp addr=ff data=e002", log_addr[0], log_data[0]); end
            checks++; if (log_addr[1] !== 8'h00 || log_data[1] !== 16'h0FFE)
                begin failures++; $display("FAIL wrap_second got addr=%h data=%h exp addr=00 data=0ffe", log_addr[1], log_data[1]); end
        end
    endtask

    task automatic test_count_zero();
        clear_log();
        base_addr = 8'h33; count = 9'd0; start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (in_ready !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL zero_first_cycle got ready=%b done=%b exp 0 0", in_ready, done); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL zero_done got done=%b busy=%b exp 1 0", done, busy); end
        tick();
        in_valid = 1'b0;
        checks++; if (log_addr.size() !== 0) begin failures++; $display("FAIL zero_no_writes got=%0d exp=0", log_addr.size()); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        clear_log();
        base_addr = 8'h20; count = 9'd3; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        set_fields(4'b0101, 3'd1, 3'd2, 3'd3, 4'h0, 11'h0, 1'b0, 1'b0);
        tick();
        start = 1'b1; base_addr = 8'h80; count = 9'd5;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL restart_done_timeout got done=%b exp=1", done); end
        checks++; if (log_addr.size() !== 3) begin failures++; $display("FAIL restart_write_count got=%0d exp=3", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 8'h20 || log_addr[1] !== 8'h21 || log_addr[2] !== 8'h22)
                begin failures++; $display("FAIL restart_addrs got=%h %h %h exp=20 21 22", log_addr[0], log_addr[1], log_addr[2]); end
        end
        tick();
    endtask

    task automatic test_random_valid();
        logic [15:0] exp_w[4];
        int idx;
        int cyc;
        exp_w[0] = 16'h11C1; exp_w[1] = 16'h238F; exp_w[2] = 16'h3559; exp_w[3] = 16'h4727;
        clear_log();
        base_addr = 8'h40; count = 9'd4; start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            set_fields(4'(idx + 1), 3'(idx), 3'(7 - idx), 3'd0, 4'(idx * 3), 11'h0, idx[0], 1'b1);
            in_valid = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL random_done_timeout got done=%b exp=1", done); end
        checks++; if (log_addr.size() !== 4) begin failures++; $display("FAIL random_write_count got=%0d exp=4", log_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (log_addr[i] !== 8'(8'h40 + i) || log_data[i] !== exp_w[i])
                    begin failures++; $display("FAIL random_word%0d got addr=%h data=%h exp addr=%h data=%h", i, log_addr[i], log_data[i], 8'(8'h40 + i), exp_w[i]); end
            end
        end
`ifdef IENC_CHECKSUM_EN
        checks++; if (checksum !== 16'h4030) begin failures++; $display("FAIL random_checksum got=%h exp=4030", checksum); end
`else
        checks++; if (checksum !== 16'h0) begin failures++; $display("FAIL random_checksum got=%h exp=0000", checksum); end
`endif
        tick();
    endtask

    task automatic test_reset_midload();
        int done_before;
        clear_log();
        base_addr = 8'h30; count = 9'd5; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        set_fields(4'b0011, 3'd3, 3'd3, 3'd3, 4'h0, 11'h0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        done_before = done_seen;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0 ||
                      busy !== 1'b0 || done !== 1'b0 || checksum !== 16'h0)
            begin failures++; $display("FAIL midreset_outputs got ready=%b we=%b addr=%h data=%h busy=%b done=%b csum=%h exp all zero",
                                       in_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum); end
        tick();
        tick();
        tick();
        checks++; if (done_seen !== done_before) begin failures++; $display("FAIL midreset_no_done got=%0d exp=%0d", done_seen, done_before); end
        checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL midreset_write_count got=%0d exp=2", log_addr.size()); end
        clear_log();
        base_addr = 8'h50; count = 9'd1; start = 1'b1;
        tick();
        start = 1'b0;
        set_fields(4'b0110, 3'd0, 3'd0, 3'd0, 4'h0, 11'h0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h50 || mem_wdata !== 16'h6000)
            begin failures++; $display("FAIL midreset_restart_write got we=%b addr=%h data=%h exp we=1 addr=50 data=6000", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL midreset_restart_done got=%b exp=1", done); end
        tick();
    endtask

    initial begin
        checks = 0; failures = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        set_fields(4'h0, 3'd0, 3'd0, 3'd0, 4'h0, 11'h0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_wrap();
        test_count_zero();
        test_start_ignored();
        test_random_valid();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
